// File: rtl/sram_like_if.sv
// Sram-like memory bus between a cache-side initiator (master) and a memory
// responder (slave): request/address/write-data one way, handshakes and read data back.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_mem_slave.sv
// Single-outstanding sram-like responder backed by a byte-lane-writable word RAM.
// Define SRAM_RAND_DELAY_EN to add an LFSR-driven 0..3 cycle jitter to data latency.
module sram_like_mem_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR_LAT   = 0,
  parameter int DATA_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  sram_like_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int ACNT_W = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
  localparam int DCNT_W = $clog2(DATA_LAT + 4) + 1;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  genvar gi;

  state_t                  state_reg, state_next;
  logic [ACNT_W-1:0]       acnt_reg, acnt_next;
  logic [DCNT_W-1:0]       dcnt_reg, dcnt_next;
  logic                    wr_reg;
  logic [3:0]              mask_reg;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [31:0]             wdata_reg;
  logic [31:0]             rd_word_reg;
  logic [31:0]             mem [DEPTH];
  logic                    accept;
  logic [3:0]              mask_in;
  logic [3:0]              lane_we;
  logic [DCNT_W-1:0]       extra_delay;
  logic                    unused_addr_hi;

  // Upper address bits alias onto the same words.
  assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

  assign bus.addr_ok = bus.req & (state_reg == IDLE) &
                       (acnt_reg == ACNT_W'(ADDR_LAT)) & ~rst;
  assign accept      = bus.addr_ok;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 8'hA5;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign extra_delay = DCNT_W'(lfsr_reg[1:0]);
`else
  assign extra_delay = '0;
`endif

  always_comb begin
    mask_in = 4'b1111;
    case (bus.size)
      2'b00:   mask_in = 4'b0001 << bus.addr[1:0];
      2'b01:   mask_in = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: mask_in = 4'b1111;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    acnt_next  = acnt_reg;
    dcnt_next  = dcnt_reg;
    case (state_reg)
      IDLE: begin
        if (!bus.req) begin
          acnt_next = '0;
        end else if (acnt_reg != ACNT_W'(ADDR_LAT)) begin
          acnt_next = acnt_reg + ACNT_W'(1);
        end
        if (accept) begin
          state_next = DATA;
          acnt_next  = '0;
          dcnt_next  = DCNT_W'(DATA_LAT - 1) + extra_delay;
        end
      end
      DATA: begin
        acnt_next = '0;
        if (dcnt_reg == '0) begin
          state_next = RESP;
        end else begin
          dcnt_next = dcnt_reg - DCNT_W'(1);
        end
      end
      RESP: begin
        acnt_next  = '0;
        state_next = IDLE;
      end
      default: begin
        acnt_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acnt_reg  <= '0;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      acnt_reg  <= acnt_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg    <= 1'b0;
      mask_reg  <= '0;
      idx_reg   <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      wr_reg    <= bus.wr;
      mask_reg  <= mask_in;
      idx_reg   <= bus.addr[ADDR_WIDTH+1:2];
      wdata_reg <= bus.wdata;
    end
  end

  // A write commits only on the RESP edge, so a reset during DATA drops it.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_we
      assign lane_we[gi] = (state_reg == RESP) & wr_reg & mask_reg[gi] & ~rst;
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[idx_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
      end
    end
  end

  // Registered read; the DATA->RESP edge captures the word before any RESP write.
  always_ff @(posedge clk) begin
    rd_word_reg <= mem[idx_reg];
  end

  assign bus.data_ok = (state_reg == RESP) & ~rst;
  assign bus.rdata   = (bus.data_ok & ~wr_reg) ? rd_word_reg : 32'h0;
endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: two configurations (lat 0/1 and 2/3) checked each
// cycle against a byte-level reference memory plus directed literal expectations.
module tb_sram_like_mem_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_d   [2];
  logic        wr_d    [2];
  logic [1:0]  size_d  [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic [31:0] rdata_o [2];
  logic [1:0]  aok;
  logic [1:0]  dok;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int AL = (gi == 0) ? 0 : 2;
    localparam int DL = (gi == 0) ? 1 : 3;

    sram_like_if bus();

    assign bus.req     = req_d[gi];
    assign bus.wr      = wr_d[gi];
    assign bus.size    = size_d[gi];
    assign bus.addr    = addr_d[gi];
    assign bus.wdata   = wdata_d[gi];
    assign aok[gi]     = bus.addr_ok;
    assign dok[gi]     = bus.data_ok;
    assign rdata_o[gi] = bus.rdata;

    sram_like_mem_slave #(
      .ADDR_WIDTH(10),
      .ADDR_LAT  (AL),
      .DATA_LAT  (DL)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    // Reference: byte-addressed memory, one pending transaction with a due cycle.
    logic [7:0]  mb [int];
    bit          busy = 1'b0;
    bit          p_wr;
    int          due;
    int          run = 0;
    int          p_idx;
    bit [3:0]    p_mask;
    logic [31:0] p_wd;

    always @(negedge clk) begin
      bit          exp_aok, exp_dok, known;
      logic [31:0] exp_rd;
      int          n, first;
      if (rst) begin
        chk($sformatf("cfg%0d addr_ok in reset", gi), 32'(aok[gi]), 32'd0);
        chk($sformatf("cfg%0d data_ok in reset", gi), 32'(dok[gi]), 32'd0);
        chk($sformatf("cfg%0d rdata in reset", gi), rdata_o[gi], 32'd0);
        busy = 1'b0;
        run  = 0;
      end else begin
        exp_aok = !busy && req_d[gi] && (run >= AL);
`ifdef SRAM_RAND_DELAY_EN
        exp_dok = busy && ((cyc == due + 3) ? 1'b1 : ((cyc >= due) ? dok[gi] : 1'b0));
`else
        exp_dok = busy && (cyc == due);
`endif
        exp_rd = 32'h0;
        known  = 1'b1;
        if (exp_dok && !p_wr) begin
          for (int b = 0; b < 4; b++) begin
            if (mb.exists(p_idx * 4 + b)) exp_rd[8*b +: 8] = mb[p_idx * 4 + b];
            else known = 1'b0;
          end
        end
        chk($sformatf("cfg%0d addr_ok", gi), 32'(aok[gi]), 32'(exp_aok));
        chk($sformatf("cfg%0d data_ok", gi), 32'(dok[gi]), 32'(exp_dok));
        if (known) chk($sformatf("cfg%0d rdata", gi), rdata_o[gi], exp_rd);

        if (exp_dok) begin
          if (p_wr) begin
            for (int b = 0; b < 4; b++)
              if (p_mask[b]) mb[p_idx * 4 + b] = p_wd[8*b +: 8];
          end
          busy = 1'b0;
          run  = 0;
        end else if (busy) begin
          run = 0;
        end else if (exp_aok) begin
          busy  = 1'b1;
          due   = cyc + DL + 1;
          p_wr  = wr_d[gi];
          p_idx = int'((addr_d[gi] >> 2) & 32'h3FF);
          p_wd  = wdata_d[gi];
          n     = (size_d[gi] == 2'b00) ? 1 : (size_d[gi] == 2'b01) ? 2 : 4;
          first = (int'(addr_d[gi][1:0]) / n) * n;
          for (int b = 0; b < 4; b++) p_mask[b] = (b >= first) && (b < first + n);
          run = 0;
        end else begin
          run = req_d[gi] ? run + 1 : 0;
        end
      end
    end
  end

  task automatic start_txn(input int k, input bit w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int c0, output int acc);
    @(posedge clk);
    #1;
    req_d[k] = 1'b1; wr_d[k] = w; size_d[k] = sz; addr_d[k] = a; wdata_d[k] = wd;
    c0  = cyc;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if (aok[k]) acc = cyc;
    end
    if (acc < 0) chk("accept timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_d[k] = 1'b0;
  endtask

  task automatic wait_dok(input int k, output int dc, output logic [31:0] rd);
    dc = -1;
    rd = 32'h0;
    for (int i = 0; i < 50 && dc < 0; i++) begin
      @(negedge clk);
      if (dok[k]) begin
        dc = cyc;
        rd = rdata_o[k];
      end
    end
    if (dc < 0) chk("data_ok timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input int k, input bit w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int acc_lat, output int dok_lat);
    int c0, acc, dc;
    start_txn(k, w, sz, a, wd, c0, acc);
    wait_dok(k, dc, rd);
    acc_lat = acc - c0;
    dok_lat = dc - acc;
    $display("txn cfg%0d %s size=%0d addr=%h wdata=%h rdata=%h accept+%0d data_ok+%0d",
             k, w ? "WR" : "RD", sz, a, wd, rd, acc_lat, dok_lat);
  endtask

`ifdef SRAM_RAND_DELAY_EN
  localparam int N_BTB = 200;
`else
  localparam int N_BTB = 12;
`endif

  initial begin
    logic [31:0] rd;
    int          al, dl, c0, acc, cnt, dc;
    bit [3:0]    seen;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_d[k] = 1'b1; wr_d[k] = 1'b0; size_d[k] = 2'b10; addr_d[k] = 32'h0; wdata_d[k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("addr_ok first cycle after rst", 32'(aok[0]), 32'd1);
    @(posedge clk);
    #1 begin req_d[0] = 1'b0; req_d[1] = 1'b0; end
    repeat (5) @(posedge clk);

    // Word write then read
    txn(0, 1'b1, 2'b10, 32'h0000_0040, 32'hDEAD_BEEF, rd, al, dl);
    chk("cfg0 write accept latency", al, 0);
`ifndef SRAM_RAND_DELAY_EN
    chk("cfg0 write data_ok latency", dl, 2);
`endif
    txn(0, 1'b0, 2'b10, 32'h0000_0040, 32'h0, rd, al, dl);
`ifndef SRAM_RAND_DELAY_EN
    chk("cfg0 read data_ok latency", dl, 2);
`endif
    chk("read DEADBEEF", rd, 32'hDEAD_BEEF);

    // Byte / halfword masks
    txn(0, 1'b1, 2'b10, 32'h0000_0040, 32'h1122_3344, rd, al, dl);
    txn(0, 1'b1, 2'b00, 32'h0000_0043, 32'hAA00_0000, rd, al, dl);
    txn(0, 1'b1, 2'b01, 32'h0000_0040, 32'h0000_5566, rd, al, dl);
    txn(0, 1'b0, 2'b10, 32'h0000_0040, 32'h0, rd, al, dl);
    chk("sb+sh merge", rd, 32'hAA22_5566);

    // size 11 as word, byte at lane 1, halfword with addr[0]=1
    txn(0, 1'b1, 2'b11, 32'h0000_0044, 32'h0102_0304, rd, al, dl);
    txn(0, 1'b1, 2'b00, 32'h0000_0045, 32'h0000_BB00, rd, al, dl);
    txn(0, 1'b1, 2'b01, 32'h0000_0047, 32'hCCDD_0000, rd, al, dl);
    txn(0, 1'b0, 2'b10, 32'h0000_0044, 32'h0, rd, al, dl);
    chk("size11/lane1/upper half", rd, 32'hCCDD_BB04);

    // High address bits alias
    txn(0, 1'b1, 2'b10, 32'hFFFF_F048, 32'h1357_9BDF, rd, al, dl);
    txn(0, 1'b0, 2'b10, 32'h0000_0048, 32'h0, rd, al, dl);
    chk("aliased address", rd, 32'h1357_9BDF);

    // ADDR_LAT=2, DATA_LAT=3
    txn(1, 1'b1, 2'b10, 32'h0000_0080, 32'hCAFE_F00D, rd, al, dl);
    chk("cfg1 addr_ok cycle", al, 2);
`ifndef SRAM_RAND_DELAY_EN
    chk("cfg1 data_ok cycle", al + dl, 6);
`endif
    @(posedge clk);
    #1 begin req_d[1] = 1'b1; wr_d[1] = 1'b0; addr_d[1] = 32'h80; end
    @(posedge clk);
    #1 req_d[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt += int'(aok[1]) + int'(dok[1]);
    end
    chk("1-cycle req pulse ignored", cnt, 0);

    // Reset one cycle after accepting a write
    start_txn(1, 1'b1, 2'b10, 32'h0000_0080, 32'h1234_5678, c0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt += int'(dok[1]);
    end
    chk("no data_ok after reset", cnt, 0);
    txn(1, 1'b0, 2'b10, 32'h0000_0080, 32'h0, rd, al, dl);
    chk("write discarded by reset", rd, 32'hCAFE_F00D);

    // Back-to-back reads
    seen = '0;
    for (int i = 0; i < N_BTB; i++) begin
      txn(0, 1'b0, 2'b10, (i % 2 == 0) ? 32'h40 : 32'h48, 32'h0, rd, al, dl);
      chk("b2b data_ok latency range", 32'((dl >= 2) && (dl <= 5)), 32'd1);
      if (dl >= 2 && dl <= 5) seen[dl - 2] = 1'b1;
    end
`ifdef SRAM_RAND_DELAY_EN
    chk("all four extra delays seen", 32'(seen), 32'hF);
`else
    chk("fixed latency only", 32'(seen), 32'h1);
`endif

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
